// File: rtl/uart_rx_param.sv
// uart_rx_param
//   Parametrised UART receiver. It takes an asynchronous serial line, idle high
//   and LSB first, and delivers each received word on a byte-wide valid/ready
//   stream. The line passes through a 2-FF synchroniser and each bit is sampled
//   at mid-bit. Bad stop bits and overruns are reported as 1-cycle pulses. An
//   active-low activity LED is retriggered on every start bit.
//
//   Optional feature: define UART_RX_PARITY_EN to expect one parity bit after
//   the data bits (PARITY_ODD selects odd/even) and to drive PARITY_ERR.
//   When the macro is undefined, no parity bit is expected and PARITY_ERR is 0.
//
// Ports
//   FPGA_CLK    in   1          system clock
//   RST_N       in   1          asynchronous active-low reset
//   UART_RXD    in   1          asynchronous serial input, idle high
//   RX_DATA     out  DATA_BITS  received word, stable while RX_VALID=1
//   RX_VALID    out  1          RX_DATA holds an unconsumed word
//   RX_READY    in   1          consumer accepts (transfer on RX_VALID & RX_READY)
//   FRAME_ERR   out  1          1-cycle pulse, stop bit sampled low
//   OVERRUN     out  1          1-cycle pulse, good frame dropped because word unconsumed
//   PARITY_ERR  out  1          1-cycle pulse, parity mismatch
//   LED_ACT     out  1          active-low activity LED
//
// State  | meaning
// -------+---------------------------------------------------------------
// IDLE   | line idle, waiting for a falling edge on the synchronised input
// START  | timing to the middle of the start bit to reject glitches
// DATA   | sampling DATA_BITS data bits, one per bit period
// PARITY | sampling the parity bit (only with UART_RX_PARITY_EN)
// STOP   | sampling STOP_BITS stop bits; the last sample completes the frame

module uart_rx_param #(
  parameter int CLK_HZ          = 50_000_000,
  parameter int BAUD            = 115_200,
  parameter int DATA_BITS       = 8,
  parameter int STOP_BITS       = 1,
  parameter int LED_HOLD_CYCLES = 50_000_000,
  parameter int PARITY_ODD      = 0
) (
  input  logic                 FPGA_CLK,
  input  logic                 RST_N,
  input  logic                 UART_RXD,
  output logic [DATA_BITS-1:0] RX_DATA,
  output logic                 RX_VALID,
  input  logic                 RX_READY,
  output logic                 FRAME_ERR,
  output logic                 OVERRUN,
  output logic                 PARITY_ERR,
  output logic                 LED_ACT
);

  localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
  localparam int CNT_W        = $clog2(CLKS_PER_BIT);
  localparam int BIT_W        = $clog2(DATA_BITS);
  localparam int LED_W        = $clog2(LED_HOLD_CYCLES + 1);

  localparam logic [CNT_W-1:0] HALF_TC   = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_TC   = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(DATA_BITS - 1);
  localparam logic             LAST_STOP = 1'(STOP_BITS - 1);
  localparam logic [LED_W-1:0] LED_LOAD  = LED_W'(LED_HOLD_CYCLES);
  localparam logic             PAR_ODD   = (PARITY_ODD != 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_RX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  state_t state, state_nxt;

  logic                 rx_meta, rxs, rxs_d;
  logic                 rx_fall;
  logic [CNT_W-1:0]     cnt;
  logic [BIT_W-1:0]     bit_idx;
  logic                 stop_idx;
  logic                 stop_bad;
  logic                 par_bad;
  logic [DATA_BITS-1:0] shift;
  logic [LED_W-1:0]     led_cnt;

  logic start_go, bit_tick, par_tick, stop_tick, frame_done;
  logic frame_bad, frame_good, load_word;

  // Synchroniser and edge history; all reset to the idle line level so that
  // reset release never looks like a start edge.
  always_ff @(posedge FPGA_CLK or negedge RST_N) begin
    if (!RST_N) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
      rxs_d   <= 1'b1;
    end else begin
      rx_meta <= UART_RXD;
      rxs     <= rx_meta;
      rxs_d   <= rxs;
    end
  end

  assign rx_fall = rxs_d & ~rxs;

  always_ff @(posedge FPGA_CLK or negedge RST_N) begin
    if (!RST_N) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    start_go   = 1'b0;
    bit_tick   = 1'b0;
    par_tick   = 1'b0;
    stop_tick  = 1'b0;
    frame_done = 1'b0;
    case (state)
      S_IDLE: begin
        if (rx_fall) begin
          state_nxt = S_START;
          start_go  = 1'b1;
        end
      end
      S_START: begin
        if (cnt == HALF_TC) state_nxt = rxs ? S_IDLE : S_DATA;
      end
      S_DATA: begin
        if (cnt == FULL_TC) begin
          bit_tick = 1'b1;
          if (bit_idx == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
            state_nxt = S_PARITY;
`else
            state_nxt = S_STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (cnt == FULL_TC) begin
          par_tick  = 1'b1;
          state_nxt = S_STOP;
        end
      end
`endif
      S_STOP: begin
        if (cnt == FULL_TC) begin
          stop_tick = 1'b1;
          // Leaving at mid stop bit lets IDLE catch a start edge that arrives
          // in the second half of the stop bit.
          if (stop_idx == LAST_STOP) begin
            frame_done = 1'b1;
            state_nxt  = S_IDLE;
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Bit-period counter restarts on every state change and every sample, so
  // after the half-bit START wait all later samples land at mid-bit.
  always_ff @(posedge FPGA_CLK or negedge RST_N) begin
    if (!RST_N) begin
      cnt      <= '0;
      bit_idx  <= '0;
      stop_idx <= 1'b0;
      stop_bad <= 1'b0;
      shift    <= '0;
    end else begin
      if (state == S_IDLE || state_nxt != state || bit_tick || stop_tick)
        cnt <= '0;
      else
        cnt <= cnt + CNT_W'(1);

      if (start_go)      bit_idx <= '0;
      else if (bit_tick) bit_idx <= bit_idx + BIT_W'(1);

      if (start_go)       stop_idx <= 1'b0;
      else if (stop_tick) stop_idx <= stop_idx + 1'b1;

      if (start_go)              stop_bad <= 1'b0;
      else if (stop_tick && !rxs) stop_bad <= 1'b1;

      if (bit_tick) shift <= {rxs, shift[DATA_BITS-1:1]};
    end
  end

  // A frame is bad if any stop bit, including the one sampled right now, is low.
  assign frame_bad  = stop_bad | ~rxs;
  assign frame_good = frame_done & ~frame_bad & ~par_bad;
  assign load_word  = frame_good & (~RX_VALID | RX_READY);

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge FPGA_CLK or negedge RST_N) begin
    if (!RST_N) begin
      par_bad    <= 1'b0;
      PARITY_ERR <= 1'b0;
    end else begin
      if (start_go)      par_bad <= 1'b0;
      else if (par_tick) par_bad <= ((^shift) ^ rxs) != PAR_ODD;
      // Framing error takes precedence over parity for the same frame.
      PARITY_ERR <= frame_done & ~frame_bad & par_bad;
    end
  end
`else
  assign par_bad    = 1'b0;
  // No parity bit on the line; PARITY_ODD has no effect in this build.
  assign PARITY_ERR = PAR_ODD & 1'b0 & par_tick;
`endif

  always_ff @(posedge FPGA_CLK or negedge RST_N) begin
    if (!RST_N) begin
      RX_DATA   <= '0;
      RX_VALID  <= 1'b0;
      FRAME_ERR <= 1'b0;
      OVERRUN   <= 1'b0;
    end else begin
      FRAME_ERR <= frame_done & frame_bad;
      OVERRUN   <= frame_good & RX_VALID & ~RX_READY;
      // A word arriving in the same cycle as a consumer handshake replaces the
      // consumed one and keeps RX_VALID high.
      if (load_word) begin
        RX_DATA  <= shift;
        RX_VALID <= 1'b1;
      end else if (RX_VALID && RX_READY) begin
        RX_VALID <= 1'b0;
      end
    end
  end

  always_ff @(posedge FPGA_CLK or negedge RST_N) begin
    if (!RST_N)              led_cnt <= '0;
    else if (start_go)       led_cnt <= LED_LOAD;
    else if (led_cnt != '0)  led_cnt <= led_cnt - LED_W'(1);
  end

  assign LED_ACT = (led_cnt == '0);

endmodule

// File: tb/tb_uart_rx_param.sv
module tb_uart_rx_param;

  logic       FPGA_CLK;
  logic       RST_N;
  logic       UART_RXD;
  logic [7:0] RX_DATA;
  logic       RX_VALID;
  logic       RX_READY;
  logic       FRAME_ERR;
  logic       OVERRUN;
  logic       PARITY_ERR;
  logic       LED_ACT;

  int n_cmp = 0;
  int n_mis = 0;

  // monitor-owned counters
  int         valid_cyc = 0, acc_cnt = 0, fe_cnt = 0, ov_cnt = 0, pe_cnt = 0, led_low = 0;
  logic [7:0] acc_data = 8'h00;
  logic       valid_q = 1'b0;
  longint     t_valid = 0;
  longint     t_start = 0;

  // snapshots taken by the stimulus
  int b_valid, b_acc, b_fe, b_ov, b_pe, b_led;

  uart_rx_param #(
    .CLK_HZ(1_000_000), .BAUD(100_000), .DATA_BITS(8), .STOP_BITS(1),
    .LED_HOLD_CYCLES(50), .PARITY_ODD(0)
  ) dut (
    .FPGA_CLK(FPGA_CLK), .RST_N(RST_N), .UART_RXD(UART_RXD),
    .RX_DATA(RX_DATA), .RX_VALID(RX_VALID), .RX_READY(RX_READY),
    .FRAME_ERR(FRAME_ERR), .OVERRUN(OVERRUN), .PARITY_ERR(PARITY_ERR),
    .LED_ACT(LED_ACT)
  );

  initial FPGA_CLK = 1'b0;
  always #5 FPGA_CLK = ~FPGA_CLK;

  // Inputs change on the falling edge; sample 1 time unit later, when both the
  // DUT outputs and the inputs for the next rising edge are settled.
  always @(negedge FPGA_CLK) begin
    #1;
    if (RX_VALID && !valid_q) t_valid = $time;
    valid_q = RX_VALID;
    if (RX_VALID) valid_cyc++;
    if (RX_VALID && RX_READY) begin
      acc_cnt++;
      acc_data = RX_DATA;
    end
    if (FRAME_ERR)  fe_cnt++;
    if (OVERRUN)    ov_cnt++;
    if (PARITY_ERR) pe_cnt++;
    if (!LED_ACT)   led_low++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic snap();
    b_valid = valid_cyc; b_acc = acc_cnt; b_fe = fe_cnt;
    b_ov = ov_cnt; b_pe = pe_cnt; b_led = led_low;
  endtask

  // Called on a falling edge; holds the line level for n clocks.
  task automatic line_bit(input logic v, input int n);
    UART_RXD = v;
    repeat (n) @(negedge FPGA_CLK);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_v);
    t_start = $time;
    line_bit(1'b0, 10);
    for (int i = 0; i < 8; i++) line_bit(d[i], 10);
`ifdef UART_RX_PARITY_EN
    line_bit(^d, 10);
`endif
    line_bit(stop_v, 10);
    UART_RXD = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    RST_N = 1'b0; UART_RXD = 1'b1; RX_READY = 1'b0;
    repeat (3) @(negedge FPGA_CLK);
    chk("rst_valid", 32'(RX_VALID), 32'd0);
    chk("rst_data", 32'(RX_DATA), 32'h00);
    chk("rst_led", 32'(LED_ACT), 32'd1);
    chk("rst_flags", {29'd0, FRAME_ERR, OVERRUN, PARITY_ERR}, 32'd0);
    RST_N = 1'b1;
    repeat (5) @(negedge FPGA_CLK);

    // 1: 0xA5 with consumer ready
    RX_READY = 1'b1;
    snap();
    send_frame(8'hA5, 1'b1);
    repeat (20) @(negedge FPGA_CLK);
    chk("t1_acc_cnt", 32'(acc_cnt - b_acc), 32'd1);
    chk("t1_data", 32'(acc_data), 32'hA5);
    chk("t1_valid_cycles", 32'(valid_cyc - b_valid), 32'd1);
    chk("t1_errs", 32'((fe_cnt - b_fe) + (ov_cnt - b_ov) + (pe_cnt - b_pe)), 32'd0);
`ifdef UART_RX_PARITY_EN
    chk("t1_latency", 32'((t_valid - t_start) / 10), 32'd108);
`else
    chk("t1_latency", 32'((t_valid - t_start) / 10), 32'd98);
`endif

    // 2: overrun with consumer stalled
    RX_READY = 1'b0;
    snap();
    send_frame(8'h3C, 1'b1);
    send_frame(8'hC3, 1'b1);
    repeat (5) @(negedge FPGA_CLK);
    chk("t2_overrun", 32'(ov_cnt - b_ov), 32'd1);
    chk("t2_data_kept", 32'(RX_DATA), 32'h3C);
    chk("t2_valid_held", 32'(RX_VALID), 32'd1);
    chk("t2_no_accept", 32'(acc_cnt - b_acc), 32'd0);
    RX_READY = 1'b1;
    repeat (3) @(negedge FPGA_CLK);
    chk("t2_accept", 32'(acc_cnt - b_acc), 32'd1);
    chk("t2_acc_data", 32'(acc_data), 32'h3C);
    chk("t2_valid_drop", 32'(RX_VALID), 32'd0);

    // 3: stop bit low
    snap();
    send_frame(8'h55, 1'b0);
    repeat (20) @(negedge FPGA_CLK);
    chk("t3_frame_err", 32'(fe_cnt - b_fe), 32'd1);
    chk("t3_no_accept", 32'(acc_cnt - b_acc), 32'd0);
    chk("t3_valid", 32'(RX_VALID), 32'd0);
    chk("t3_data_kept", 32'(RX_DATA), 32'h3C);

    // 4: 3-cycle glitch, LED retrigger, then a clean frame
    repeat (60) @(negedge FPGA_CLK);
    chk("t4_led_idle", 32'(LED_ACT), 32'd1);
    snap();
    line_bit(1'b0, 3);
    line_bit(1'b1, 5);
    chk("t4_led_on", 32'(LED_ACT), 32'd0);
    repeat (80) @(negedge FPGA_CLK);
    chk("t4_led_low_cycles", 32'(led_low - b_led), 32'd50);
    chk("t4_led_off", 32'(LED_ACT), 32'd1);
    chk("t4_no_flags", 32'((fe_cnt - b_fe) + (ov_cnt - b_ov) + (acc_cnt - b_acc)), 32'd0);
    send_frame(8'h3A, 1'b1);
    repeat (20) @(negedge FPGA_CLK);
    chk("t4_after_glitch", 32'(acc_data), 32'h3A);

    // 5: reset in the middle of data bit 4
    snap();
    line_bit(1'b0, 10);
    line_bit(1'b0, 40);
    line_bit(1'b0, 5);
    RST_N = 1'b0;
    #1;
    chk("t5_rst_valid", 32'(RX_VALID), 32'd0);
    chk("t5_rst_data", 32'(RX_DATA), 32'h00);
    chk("t5_rst_led", 32'(LED_ACT), 32'd1);
    repeat (2) @(negedge FPGA_CLK);
    UART_RXD = 1'b1;
    repeat (2) @(negedge FPGA_CLK);
    RST_N = 1'b1;
    repeat (10) @(negedge FPGA_CLK);
    send_frame(8'h81, 1'b1);
    repeat (20) @(negedge FPGA_CLK);
    chk("t5_accept", 32'(acc_cnt - b_acc), 32'd1);
    chk("t5_data", 32'(acc_data), 32'h81);
    chk("t5_no_ferr", 32'(fe_cnt - b_fe), 32'd0);

`ifdef UART_RX_PARITY_EN
    // 6: 0x07 has three ones, even parity bit must be 1; send 0
    snap();
    line_bit(1'b0, 10);
    line_bit(1'b1, 30);
    line_bit(1'b0, 50);
    line_bit(1'b0, 10);
    line_bit(1'b1, 10);
    repeat (20) @(negedge FPGA_CLK);
    chk("t6_parity_err", 32'(pe_cnt - b_pe), 32'd1);
    chk("t6_no_accept", 32'(acc_cnt - b_acc), 32'd0);
    chk("t6_valid", 32'(RX_VALID), 32'd0);
    send_frame(8'h07, 1'b1);
    repeat (20) @(negedge FPGA_CLK);
    chk("t6_good_data", 32'(acc_data), 32'h07);
    chk("t6_no_new_perr", 32'(pe_cnt - b_pe), 32'd1);
`else
    chk("parity_err_never", 32'(pe_cnt), 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
